cdb_arbiter: RTL and testbench

//  Common-data-bus arbiter between the ALU and the store/load buffer (SLB) result ports.

---
 rtl/cdb_arbiter.sv | 139 +++++++++++++
 tb/tb_cdb_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: merges ALU and store/load-buffer results onto one
// registered broadcast bus. Each source feeds a small FIFO; one head is popped
// per cycle, round-robin between the sources. A ROB exception flushes both
// FIFOs and silences the bus.
module cdb_arbiter #(
    parameter int FifoDepth = 4,
    parameter int PtrLength = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_exception_from_rob,
    input  logic        is_finish_from_alu,
    input  logic [31:0] pc_from_alu,
    input  logic [31:0] data_from_alu,
    input  logic [31:0] jpc_from_alu,
    input  logic        is_finish_from_slb,
    input  logic [31:0] pc_from_slb,
    input  logic [31:0] data_from_slb,
    output logic        is_stall_to_alu,
    output logic        is_stall_to_slb,
    output logic        cdb_valid,
    output logic [31:0] cdb_pc,
    output logic [31:0] cdb_data,
    output logic [31:0] cdb_jpc,
    output logic        cdb_from_slb
);

    localparam int PtrW   = PtrLength + 1;
    localparam int CntW   = PtrLength + 2;
    localparam int EntryW = 96;

    // Source index 0 is the ALU, index 1 is the SLB.
    logic [1:0]             src_finish;
    logic [1:0][EntryW-1:0] src_entry;
    logic [1:0]             stall;
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0]             not_empty;
    logic [1:0][EntryW-1:0] head;
    logic                   grant_valid;
    logic                   grant_src;
    logic                   last_grant_reg;

    assign src_finish   = {is_finish_from_slb, is_finish_from_alu};
    assign src_entry[0] = {pc_from_alu, data_from_alu, jpc_from_alu};
    // Loads/stores never redirect, so their next-pc is simply pc+4.
    assign src_entry[1] = {pc_from_slb, data_from_slb, pc_from_slb + 32'd4};

    assign is_stall_to_alu = stall[0];
    assign is_stall_to_slb = stall[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [EntryW-1:0] mem [FifoDepth];
            logic [PtrW-1:0]   wr_ptr_reg;
            logic [PtrW-1:0]   rd_ptr_reg;
            logic [CntW-1:0]   count_reg;

            // Stall depends only on the registered count: a full FIFO refuses
            // a push even when the same edge pops it.
            assign stall[gi]     = (count_reg == CntW'(FifoDepth));
            assign not_empty[gi] = (count_reg != '0);
            assign push[gi]      = src_finish[gi] && !stall[gi] && !is_exception_from_rob;
            assign pop[gi]       = grant_valid && !is_exception_from_rob && (grant_src == 1'(gi));
            assign head[gi]      = mem[rd_ptr_reg];

            // Entry storage; no reset needed since count gates every read.
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= src_entry[gi];
                end
            end

            // Pointer and occupancy bookkeeping; flush empties the FIFO.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (is_exception_from_rob) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + CntW'(1);
                        2'b01:   count_reg <= count_reg - CntW'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Round-robin pick: on contention the source not granted last time wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = 1'b0;
        if (not_empty[0] && not_empty[1]) begin
            grant_valid = 1'b1;
            grant_src   = ~last_grant_reg;
        end else if (not_empty[0]) begin
            grant_valid = 1'b1;
            grant_src   = 1'b0;
        end else if (not_empty[1]) begin
            grant_valid = 1'b1;
            grant_src   = 1'b1;
        end
    end

    // Registered broadcast bus; payload holds when idle, valid pulses per grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid      <= 1'b0;
            cdb_pc         <= '0;
            cdb_data       <= '0;
            cdb_jpc        <= '0;
            cdb_from_slb   <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if (is_exception_from_rob) begin
            cdb_valid      <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if (grant_valid) begin
            cdb_valid                   <= 1'b1;
            {cdb_pc, cdb_data, cdb_jpc} <= head[grant_src];
            cdb_from_slb                <= grant_src;
            last_grant_reg              <= grant_src;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: reset, latency, tie-break, full-FIFO
// stalling, flush and pointer wrap.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        exc;
    logic        fa;
    logic [31:0] pa;
    logic [31:0] da;
    logic [31:0] ja;
    logic        fs;
    logic [31:0] ps;
    logic [31:0] ds;
    logic        st_a;
    logic        st_s;
    logic        cv;
    logic [31:0] cpc;
    logic [31:0] cdata;
    logic [31:0] cjpc;
    logic        cfs;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.FifoDepth(4), .PtrLength(1)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .is_exception_from_rob (exc),
        .is_finish_from_alu    (fa),
        .pc_from_alu           (pa),
        .data_from_alu         (da),
        .jpc_from_alu          (ja),
        .is_finish_from_slb    (fs),
        .pc_from_slb           (ps),
        .data_from_slb         (ds),
        .is_stall_to_alu       (st_a),
        .is_stall_to_slb       (st_s),
        .cdb_valid             (cv),
        .cdb_pc                (cpc),
        .cdb_data              (cdata),
        .cdb_jpc               (cjpc),
        .cdb_from_slb          (cfs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exc = 1'b0;
        fa = 1'b0; pa = '0; da = '0; ja = '0;
        fs = 1'b0; ps = '0; ds = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #3;
        checks++;
        if ({st_a, st_s, cv, cpc, cdata, cjpc, cfs} !== 99'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {st_a, st_s, cv, cpc, cdata, cjpc, cfs});
        end
        tick();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (cv !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_valid: got %b expected 0", cv);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_alu();
        apply_reset();
        fa = 1'b1; pa = 32'h100; da = 32'h5; ja = 32'h104;
        tick();
        idle_inputs();
        checks++;
        if (cv !== 1'b0) begin
            failures++;
            $display("FAIL single_n1_valid: got %b expected 0", cv);
        end
        tick();
        checks++;
        if ({cv, cpc, cdata, cjpc, cfs} !== {1'b1, 32'h100, 32'h5, 32'h104, 1'b0}) begin
            failures++;
            $display("FAIL single_n2: got v=%b pc=%h d=%h j=%h s=%b expected v=1 pc=100 d=5 j=104 s=0",
                     cv, cpc, cdata, cjpc, cfs);
        end
        tick();
        checks++;
        if (cv !== 1'b0) begin
            failures++;
            $display("FAIL single_n3_valid: got %b expected 0", cv);
        end
        $display("test_single_alu done pc=%h", cpc);
    endtask

    task automatic test_tie();
        apply_reset();
        fa = 1'b1; pa = 32'h10; da = 32'h1; ja = 32'h14;
        fs = 1'b1; ps = 32'h20; ds = 32'h7;
        tick();
        idle_inputs();
        tick();
        checks++;
        if ({cv, cpc, cdata, cjpc, cfs} !== {1'b1, 32'h10, 32'h1, 32'h14, 1'b0}) begin
            failures++;
            $display("FAIL tie_alu_first: got v=%b pc=%h d=%h j=%h s=%b expected v=1 pc=10 d=1 j=14 s=0",
                     cv, cpc, cdata, cjpc, cfs);
        end
        tick();
        checks++;
        if ({cv, cpc, cdata, cjpc, cfs} !== {1'b1, 32'h20, 32'h7, 32'h24, 1'b1}) begin
            failures++;
            $display("FAIL tie_slb_second: got v=%b pc=%h d=%h j=%h s=%b expected v=1 pc=20 d=7 j=24 s=1",
                     cv, cpc, cdata, cjpc, cfs);
        end
        tick();
        checks++;
        if (cv !== 1'b0) begin
            failures++;
            $display("FAIL tie_after_valid: got %b expected 0", cv);
        end
        $display("test_tie done");
    endtask

    task automatic test_full();
        int occ_a, occ_s, a_sent, s_sent, a_rx, s_rx, cyc;
        logic last, exp_valid, exp_src, acc_a, acc_s, exp_st_a, exp_st_s, saw_a, saw_s;
        logic [31:0] exp_pc, exp_data, exp_jpc;
        apply_reset();
        occ_a = 0; occ_s = 0; a_sent = 0; s_sent = 0; a_rx = 0; s_rx = 0; cyc = 0;
        last = 1'b1; saw_a = 1'b0; saw_s = 1'b0;
        while ((a_rx < 20 || s_rx < 20) && cyc < 200) begin
            exp_st_a = (occ_a == 4);
            exp_st_s = (occ_s == 4);
            checks++;
            if (st_a !== exp_st_a) begin
                failures++;
                $display("FAIL full_stall_alu cyc=%0d: got %b expected %b", cyc, st_a, exp_st_a);
            end
            checks++;
            if (st_s !== exp_st_s) begin
                failures++;
                $display("FAIL full_stall_slb cyc=%0d: got %b expected %b", cyc, st_s, exp_st_s);
            end
            if (st_a) saw_a = 1'b1;
            if (st_s) saw_s = 1'b1;
            fa = (a_sent < 20); pa = 32'h1000 + 32'(a_sent * 4); da = ~pa; ja = pa + 32'd8;
            fs = (s_sent < 20); ps = 32'h2000 + 32'(s_sent * 4); ds = ps + 32'h1000_0000;
            acc_a = fa && !exp_st_a;
            acc_s = fs && !exp_st_s;
            exp_valid = (occ_a > 0) || (occ_s > 0);
            exp_src   = (occ_a > 0 && occ_s > 0) ? ~last : (occ_s > 0);
            tick();
            checks++;
            if (cv !== exp_valid) begin
                failures++;
                $display("FAIL full_valid cyc=%0d: got %b expected %b", cyc, cv, exp_valid);
            end
            if (exp_valid) begin
                if (exp_src) begin
                    exp_pc = 32'h2000 + 32'(s_rx * 4); exp_data = exp_pc + 32'h1000_0000; exp_jpc = exp_pc + 32'd4;
                    s_rx++; occ_s--;
                end else begin
                    exp_pc = 32'h1000 + 32'(a_rx * 4); exp_data = ~exp_pc; exp_jpc = exp_pc + 32'd8;
                    a_rx++; occ_a--;
                end
                checks++;
                if ({cfs, cpc, cdata, cjpc} !== {exp_src, exp_pc, exp_data, exp_jpc}) begin
                    failures++;
                    $display("FAIL full_grant cyc=%0d: got s=%b pc=%h d=%h j=%h expected s=%b pc=%h d=%h j=%h",
                             cyc, cfs, cpc, cdata, cjpc, exp_src, exp_pc, exp_data, exp_jpc);
                end
                last = exp_src;
            end
            if (acc_a) begin a_sent++; occ_a++; end
            if (acc_s) begin s_sent++; occ_s++; end
            cyc++;
        end
        idle_inputs();
        checks++;
        if (cyc >= 200) begin
            failures++;
            $display("FAIL full_timeout: got %0d cycles expected under 200", cyc);
        end
        checks++;
        if ({saw_a, saw_s} !== 2'b11) begin
            failures++;
            $display("FAIL full_stall_seen: got %b expected 11", {saw_a, saw_s});
        end
        tick();
        checks++;
        if (cv !== 1'b0) begin
            failures++;
            $display("FAIL full_drained_valid: got %b expected 0", cv);
        end
        $display("test_full done cycles=%0d alu=%0d slb=%0d", cyc, a_rx, s_rx);
    endtask

    task automatic test_flush();
        apply_reset();
        fa = 1'b1; pa = 32'h300; da = 32'h30; ja = 32'h304;
        fs = 1'b1; ps = 32'h400; ds = 32'h40;
        tick();
        pa = 32'h304; da = 32'h31; ja = 32'h308;
        ps = 32'h404; ds = 32'h41;
        tick();
        checks++;
        if ({cv, cpc, cfs} !== {1'b1, 32'h300, 1'b0}) begin
            failures++;
            $display("FAIL flush_pre1: got v=%b pc=%h s=%b expected v=1 pc=300 s=0", cv, cpc, cfs);
        end
        pa = 32'h308; da = 32'h32; ja = 32'h30c;
        fs = 1'b0;
        tick();
        checks++;
        if ({cv, cpc, cfs} !== {1'b1, 32'h400, 1'b1}) begin
            failures++;
            $display("FAIL flush_pre2: got v=%b pc=%h s=%b expected v=1 pc=400 s=1", cv, cpc, cfs);
        end
        fa = 1'b0;
        tick();
        checks++;
        if ({cv, cpc, cfs} !== {1'b1, 32'h304, 1'b0}) begin
            failures++;
            $display("FAIL flush_pre3: got v=%b pc=%h s=%b expected v=1 pc=304 s=0", cv, cpc, cfs);
        end
        // ALU 0x308 and SLB 0x404 remain queued; flush while new results arrive.
        exc = 1'b1;
        fa = 1'b1; pa = 32'h3f0; da = 32'h3f; ja = 32'h3f4;
        fs = 1'b1; ps = 32'h4f0; ds = 32'h4f;
        tick();
        idle_inputs();
        checks++;
        if ({cv, st_a, st_s} !== 3'b000) begin
            failures++;
            $display("FAIL flush_next: got v=%b stall=%b%b expected 000", cv, st_a, st_s);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (cv !== 1'b0) begin
                failures++;
                $display("FAIL flush_quiet i=%0d: got v=%b pc=%h expected v=0", i, cv, cpc);
            end
        end
        fa = 1'b1; pa = 32'h500; da = 32'h50; ja = 32'h504;
        fs = 1'b1; ps = 32'h600; ds = 32'h60;
        tick();
        idle_inputs();
        checks++;
        if (cv !== 1'b0) begin
            failures++;
            $display("FAIL flush_post_n1: got %b expected 0", cv);
        end
        tick();
        checks++;
        if ({cv, cpc, cfs} !== {1'b1, 32'h500, 1'b0}) begin
            failures++;
            $display("FAIL flush_post_alu: got v=%b pc=%h s=%b expected v=1 pc=500 s=0", cv, cpc, cfs);
        end
        tick();
        checks++;
        if ({cv, cpc, cjpc, cfs} !== {1'b1, 32'h600, 32'h604, 1'b1}) begin
            failures++;
            $display("FAIL flush_post_slb: got v=%b pc=%h j=%h s=%b expected v=1 pc=600 j=604 s=1",
                     cv, cpc, cjpc, cfs);
        end
        tick();
        checks++;
        if (cv !== 1'b0) begin
            failures++;
            $display("FAIL flush_post_idle: got %b expected 0", cv);
        end
        $display("test_flush done");
    endtask

    task automatic test_wrap();
        int a_sent, s_sent, a_rx, s_rx;
        logic acc_a, acc_s;
        apply_reset();
        a_sent = 0; s_sent = 0; a_rx = 0; s_rx = 0;
        for (int c = 0; c < 60; c++) begin
            fa = ((c % 3) == 0) && (a_sent < 9);
            pa = 32'(a_sent * 4); da = 32'hd000_0000 | pa; ja = pa + 32'd4;
            fs = ((c % 3) == 1) && (s_sent < 6);
            ps = 32'h800 + 32'(s_sent * 4); ds = 32'he000_0000 | ps;
            acc_a = fa && !st_a;
            acc_s = fs && !st_s;
            tick();
            if (acc_a) a_sent++;
            if (acc_s) s_sent++;
            if (cv) begin
                checks++;
                if (!cfs) begin
                    if (a_rx >= 9 || cpc !== 32'(a_rx * 4) || cdata !== (32'hd000_0000 | cpc)) begin
                        failures++;
                        $display("FAIL wrap_alu idx=%0d: got pc=%h d=%h expected pc=%h", a_rx, cpc, cdata, 32'(a_rx * 4));
                    end
                    a_rx++;
                end else begin
                    if (s_rx >= 6 || cpc !== 32'h800 + 32'(s_rx * 4)) begin
                        failures++;
                        $display("FAIL wrap_slb idx=%0d: got pc=%h expected pc=%h", s_rx, cpc, 32'h800 + 32'(s_rx * 4));
                    end
                    s_rx++;
                end
            end
        end
        idle_inputs();
        checks++;
        if (a_rx != 9) begin
            failures++;
            $display("FAIL wrap_alu_count: got %0d expected 9", a_rx);
        end
        checks++;
        if (s_rx != 6) begin
            failures++;
            $display("FAIL wrap_slb_count: got %0d expected 6", s_rx);
        end
        $display("test_wrap done alu=%0d slb=%0d", a_rx, s_rx);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fa = 1'b1; pa = 32'h700; da = 32'h70; ja = 32'h704;
        tick();
        pa = 32'h704; da = 32'h71; ja = 32'h708;
        tick();
        checks++;
        if ({cv, cpc} !== {1'b1, 32'h700}) begin
            failures++;
            $display("FAIL rstmid_pre: got v=%b pc=%h expected v=1 pc=700", cv, cpc);
        end
        pa = 32'h708; da = 32'h72; ja = 32'h70c;
        tick();
        idle_inputs();
        // 0x708 is still queued; assert reset between clock edges.
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({st_a, st_s, cv, cpc, cdata, cjpc, cfs} !== 99'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got %h expected 0", {st_a, st_s, cv, cpc, cdata, cjpc, cfs});
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cv !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_quiet i=%0d: got v=%b pc=%h expected v=0", i, cv, cpc);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_alu();
        test_tie();
        test_full();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
